// File: rtl/ram_access_arbiter_pkg.sv
// Shared command-RAM definitions: opcodes, widths and arbiter state encoding.
package ram_cmd_pkg;

   localparam int CMD_W  = 10;
   localparam int DATA_W = 8;

   typedef logic [1:0] opcode_t;

   localparam opcode_t OP_WR_ADDR = 2'b00;
   localparam opcode_t OP_WR_DATA = 2'b01;
   localparam opcode_t OP_RD_ADDR = 2'b10;
   localparam opcode_t OP_RD_DATA = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCKED  = 2'd1,
      WAIT_RD = 2'd2
   } arb_state_t;

   function automatic opcode_t cmd_op(input logic [CMD_W-1:0] cmd);
      return cmd[CMD_W-1:CMD_W-2];
   endfunction

   // Address opcodes (00, 10) are the only ones that may open a transaction.
   function automatic logic is_addr_op(input logic [CMD_W-1:0] cmd);
      return (cmd_op(cmd) == OP_WR_ADDR) || (cmd_op(cmd) == OP_RD_ADDR);
   endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester, response, RAM and status signals of the command-RAM arbiter.
interface ram_access_arbiter_if;
   import ram_cmd_pkg::*;

   logic              req0_valid;
   logic [CMD_W-1:0]  req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [CMD_W-1:0]  req1_data;
   logic              req1_ready;
   logic              rsp0_valid;
   logic              rsp1_valid;
   logic [DATA_W-1:0] rsp_data;
   logic [CMD_W-1:0]  ram_din;
   logic              ram_rx_valid;
   logic [DATA_W-1:0] ram_dout;
   logic              ram_tx_valid;
   logic              busy;
   logic              timeout;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, ram_dout, ram_tx_valid,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
             ram_din, ram_rx_valid, busy, timeout
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, ram_dout, ram_tx_valid,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
             ram_din, ram_rx_valid, busy, timeout
   );

endinterface

// File: rtl/ram_access_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: ptr selects the winner only when both are eligible.
module rr_arbiter2 (
   input  logic [1:0] elig,
   input  logic       ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant    = 2'b00;
      grant[0] = elig[0] & (~elig[1] | ~ptr);
      grant[1] = elig[1] & (~elig[0] |  ptr);
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port command RAM between two requesters, keeping each
// address/data pair atomic, with lock and read-data timeouts.
//
// state   | meaning
// IDLE    | no owner; address commands compete round-robin, stray data dropped
// LOCKED  | owner holds the RAM between its address and data commands
// WAIT_RD | read-data command forwarded; waiting for ram_tx_valid
module ram_access_arbiter
   import ram_cmd_pkg::*;
#(
   parameter int LOCK_TIMEOUT = 64,
   parameter int RD_TIMEOUT   = 16,
   parameter int TW           = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   ram_access_arbiter_if.slave  bus
);

   localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] RD_LAST   = TW'(RD_TIMEOUT - 1);

   arb_state_t        state, state_nxt;
   logic              owner, owner_nxt;
   logic              rr_ptr, rr_ptr_nxt;
   logic [TW-1:0]     timer, timer_nxt;

   logic [CMD_W-1:0]  ram_din_q, ram_din_nxt;
   logic              ram_rx_valid_q, ram_rx_valid_nxt;
   logic              rsp0_valid_q, rsp0_valid_nxt;
   logic              rsp1_valid_q, rsp1_valid_nxt;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_nxt;
   logic              timeout_q, timeout_nxt;

   logic [1:0]        valid;
   logic [1:0]        addr_elig;
   logic [1:0]        stray;
   logic [1:0]        arb_req;
   logic [1:0]        grant;
   logic [1:0]        ready;
   logic [1:0]        xfer;
   logic [CMD_W-1:0]  win_cmd;
   logic [CMD_W-1:0]  owner_cmd;

   assign valid     = {bus.req1_valid, bus.req0_valid};
   assign addr_elig = valid & {is_addr_op(bus.req1_data), is_addr_op(bus.req0_data)};
   assign stray     = valid & ~addr_elig;
   // Address commands always beat stray data; strays only compete among themselves.
   assign arb_req   = (|addr_elig) ? addr_elig : stray;

   rr_arbiter2 u_rr (
      .elig  (arb_req),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   assign win_cmd   = grant[1] ? bus.req1_data : bus.req0_data;
   assign owner_cmd = owner ? bus.req1_data : bus.req0_data;

   always_comb begin
      ready = 2'b00;
      case (state)
         IDLE:    ready = grant;
         LOCKED:  ready = owner ? 2'b10 : 2'b01;
         default: ready = 2'b00;
      endcase
      if (reset)
         ready = 2'b00;
   end

   assign xfer = valid & ready;

   always_comb begin
      state_nxt        = state;
      owner_nxt        = owner;
      rr_ptr_nxt       = rr_ptr;
      timer_nxt        = timer;
      ram_din_nxt      = ram_din_q;
      ram_rx_valid_nxt = 1'b0;
      rsp0_valid_nxt   = 1'b0;
      rsp1_valid_nxt   = 1'b0;
      rsp_data_nxt     = rsp_data_q;
      timeout_nxt      = 1'b0;

      case (state)
         IDLE: begin
            if (|(xfer & addr_elig)) begin
               owner_nxt        = xfer[1];
               ram_din_nxt      = win_cmd;
               ram_rx_valid_nxt = 1'b1;
               timer_nxt        = '0;
               state_nxt        = LOCKED;
            end
         end

         LOCKED: begin
            if (|xfer) begin
               ram_din_nxt      = owner_cmd;
               ram_rx_valid_nxt = 1'b1;
               case (cmd_op(owner_cmd))
                  OP_WR_DATA: begin
                     state_nxt  = IDLE;
                     rr_ptr_nxt = ~owner;
                  end
                  OP_RD_DATA: begin
                     state_nxt = WAIT_RD;
                     timer_nxt = '0;
                  end
                  default: timer_nxt = '0;
               endcase
            end else if (timer == LOCK_LAST) begin
               timeout_nxt = 1'b1;
               state_nxt   = IDLE;
               rr_ptr_nxt  = ~owner;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end

         WAIT_RD: begin
            // Data arriving on the expiry cycle still counts as a good read.
            if (bus.ram_tx_valid) begin
               rsp_data_nxt   = bus.ram_dout;
               rsp0_valid_nxt = ~owner;
               rsp1_valid_nxt = owner;
               state_nxt      = IDLE;
               rr_ptr_nxt     = ~owner;
            end else if (timer == RD_LAST) begin
               timeout_nxt = 1'b1;
               state_nxt   = IDLE;
               rr_ptr_nxt  = ~owner;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         owner          <= 1'b0;
         rr_ptr         <= 1'b0;
         timer          <= '0;
         ram_din_q      <= '0;
         ram_rx_valid_q <= 1'b0;
         rsp0_valid_q   <= 1'b0;
         rsp1_valid_q   <= 1'b0;
         rsp_data_q     <= '0;
         timeout_q      <= 1'b0;
      end else begin
         state          <= state_nxt;
         owner          <= owner_nxt;
         rr_ptr         <= rr_ptr_nxt;
         timer          <= timer_nxt;
         ram_din_q      <= ram_din_nxt;
         ram_rx_valid_q <= ram_rx_valid_nxt;
         rsp0_valid_q   <= rsp0_valid_nxt;
         rsp1_valid_q   <= rsp1_valid_nxt;
         rsp_data_q     <= rsp_data_nxt;
         timeout_q      <= timeout_nxt;
      end
   end

   assign bus.req0_ready   = ready[0];
   assign bus.req1_ready   = ready[1];
   assign bus.ram_din      = ram_din_q;
   assign bus.ram_rx_valid = ram_rx_valid_q;
   assign bus.rsp0_valid   = rsp0_valid_q;
   assign bus.rsp1_valid   = rsp1_valid_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.timeout      = timeout_q;
   assign bus.busy         = (state != IDLE);

endmodule
